udi_thr_event_fifo: RTL

//  Downstream consumer of the UDI spectral-density compare instructions (UDI_4/5/6).

---
 rtl/udi_thr_event_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/udi_thr_event_fifo.sv
// udi_thr_event_fifo
//  Consumes retired UDI spectral-density compares. Every retired compare bumps a
//  sample index. Every hit pushes {index, magnitude} into a show-ahead FIFO, which
//  is drained through a valid/ready port. Hits that arrive while the FIFO is full
//  are dropped and counted.
// Ports
//  gclk, greset_n     clock, async active-low reset
//  gscanenable        scan enable, functionally ignored
//  cmp_valid_m/hit_m  retired compare and its result
//  cmp_mag_m          magnitude of the compare
//  clr                synchronous flush of FIFO, index counter and overflow count
//  ev_valid/ev_ready  head-entry handshake; ev_idx/ev_mag carry the head entry
//  level              occupancy, 0..DEPTH
//  ovf_cnt            saturating count of dropped hits
//  irq                registered: level >= IRQ_LEVEL or any overflow
module udi_thr_event_fifo #(
  parameter int DEPTH     = 8,
  parameter int IDX_W     = 16,
  parameter int MAG_W     = 32,
  parameter int IRQ_LEVEL = 4
) (
  input  logic                     gclk,
  input  logic                     greset_n,
  input  logic                     gscanenable,
  input  logic                     cmp_valid_m,
  input  logic                     cmp_hit_m,
  input  logic [MAG_W-1:0]         cmp_mag_m,
  input  logic                     clr,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [IDX_W-1:0]         ev_idx,
  output logic [MAG_W-1:0]         ev_mag,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_cnt,
  output logic                     irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] IRQ_LVL  = LW'(IRQ_LEVEL);

  logic unused_scan;
  assign unused_scan = gscanenable;

  logic [IDX_W-1:0] mem_idx_q [DEPTH];
  logic [MAG_W-1:0] mem_mag_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic             push, pop, full, wr_en, drop;

  assign ev_valid = (level_q != '0);
  // Head is read from the storage registers; zeroed while empty.
  assign ev_idx   = ev_valid ? mem_idx_q[rd_ptr_q] : '0;
  assign ev_mag   = ev_valid ? mem_mag_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign ovf_cnt  = ovf_q;
  assign irq      = irq_q;

  always_comb begin
    push     = cmp_valid_m & cmp_hit_m;
    pop      = ev_valid & ev_ready & ~clr;
    full     = (level_q == FULL_LVL);
    // When full, a simultaneous pop frees the slot the push lands in.
    wr_en    = push & (~full | pop) & ~clr;
    drop     = push & full & ~pop & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      idx_d    = '0;
      ovf_d    = '0;
    end else begin
      idx_d   = idx_q + IDX_W'(cmp_valid_m);
      level_d = level_q + LW'(wr_en) - LW'(pop);
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
    irq_d = (level_d >= IRQ_LVL) | (ovf_d != '0);
  end

  always_ff @(posedge gclk or negedge greset_n) begin
    if (!greset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge gclk) begin
    if (wr_en) begin
      mem_idx_q[wr_ptr_q] <= idx_q;
      mem_mag_q[wr_ptr_q] <= cmp_mag_m;
    end
  end
endmodule
